gated_shift_register: RTL and testbench
=======================================

GATED_SHIFT_REGISTER -- requirements
Module: gated_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal range 2..32.
REQ-002 The block SHALL derive localparam CW = clog2(WIDTH+1) for the shift counter width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 EN  input  1  gate; when 0, Q, CNT and DONE logic hold except for CLR.
REQ-006 CLR  input  1  synchronous clear of Q and CNT.
REQ-007 MODE  input  3  operation select, see REQ-012.
REQ-008 D  input  WIDTH  parallel load data.
REQ-009 SI_MSB  input  1  serial bit entering at Q[WIDTH-1] on logical shift right.
REQ-010 SI_LSB  input  1  serial bit entering at Q[0] on logical shift left.
REQ-011 Q  output  WIDTH  register contents; SO_MSB output 1 = Q[WIDTH-1]; SO_LSB output 1 = Q[0]; CNT output CW = shift count; DONE output 1 = completion pulse.

Function
REQ-012 MODE encoding SHALL be: 000 hold; 001 parallel load Q<=D; 010 logical shift right Q<={SI_MSB,Q[WIDTH-1:1]}; 011 logical shift left Q<={Q[WIDTH-2:0],SI_LSB}; 100 rotate right; 101 rotate left; 110 arithmetic shift right (Q[WIDTH-1] replicated); 111 hold (reserved).
REQ-013 Priority per rising edge SHALL be: CLR (regardless of EN) > EN=0 hold > MODE operation.
REQ-014 CLR=1 SHALL set Q=0, CNT=0, DONE=0 on the next edge.
REQ-015 Mode 001 with EN=1 SHALL set CNT=0 in the same edge Q is loaded.
REQ-016 Modes 010..110 with EN=1 are "shift ops"; each SHALL increment CNT by 1, saturating at WIDTH.
REQ-017 DONE SHALL be a registered one-cycle pulse, asserted in the cycle after the edge where CNT goes WIDTH-1 -> WIDTH; no reassertion while CNT is saturated.
REQ-018 DONE SHALL deassert on the next edge in every other case, including EN=0.
REQ-019 Hold modes (000, 111) and EN=0 SHALL leave Q and CNT unchanged.
REQ-020 SO_MSB and SO_LSB SHALL be combinational functions of Q only, with no added latency.
REQ-021 Latency: Q, CNT and DONE SHALL reflect an operation one clock after the sampling edge; no combinational path from D, MODE or EN to any output.
REQ-022 CNT SHALL be counted in CW-bit unsigned arithmetic with no wrap past WIDTH.
REQ-023 Rotates SHALL lose no bit; after WIDTH consecutive rotates in one direction Q SHALL equal its pre-rotate value.

Reset
REQ-024 RST_N=0 SHALL immediately, independent of CLK, force Q=0, CNT=0, DONE=0, hence SO_MSB=SO_LSB=0.
REQ-025 Reset assertion mid-sequence SHALL abort the sequence; after release the first active edge behaves as from power-up.
REQ-026 Reset deassertion SHALL be synchronised by the integrator; the block itself takes no action on release.

Verification (WIDTH=8)
REQ-027 Load D=8'hA5, MODE=001, EN=1 -> Q=8'hA5, CNT=0 next cycle; then MODE=000 for 3 cycles -> Q stays 8'hA5.
REQ-028 Q=8'h81, MODE=010, SI_MSB=0 for 8 cycles -> Q=8'h00 after 8 edges; CNT=8; DONE high exactly one cycle; SO_LSB sequence 1,0,0,0,0,0,0,1 as bits leave.
REQ-029 Q=8'h3C, MODE=101 for 8 cycles -> Q returns to 8'h3C; Q=8'h80, MODE=110 once -> Q=8'hC0.
REQ-030 Q=8'hFF, EN=0, MODE=011, CLR=1 -> Q=0, CNT=0 next edge, proving CLR beats EN=0.
REQ-031 Midway through 4 of 8 shifts assert RST_N=0 between edges -> Q=0, CNT=0 immediately; release, 8 shifts -> DONE once at shift 8.
REQ-032 Continue shifting after CNT=8 -> CNT stays 8, DONE stays 0; a load then restarts the count.

Source files
------------

// File: rtl/gated_shift_register.sv
// Gated universal shift register: load, logical/arithmetic shifts and rotates,
// with a saturating shift counter and a one-cycle completion pulse.
module gated_shift_register #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             si_msb,
  input  logic             si_lsb,
  output logic [WIDTH-1:0] q,
  output logic             so_msb,
  output logic             so_lsb,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SRL  = 3'b010,
    MODE_SLL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_SRA  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_next;
  logic             shift_op;
  logic             cnt_full;

  always_comb begin
    q_next   = q;
    shift_op = 1'b0;
    case (mode_e'(mode))
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SRL: begin
        q_next   = {si_msb, q[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      MODE_SLL: begin
        q_next   = {q[WIDTH-2:0], si_lsb};
        shift_op = 1'b1;
      end
      MODE_ROR: begin
        q_next   = {q[0], q[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      MODE_ROL: begin
        q_next   = {q[WIDTH-2:0], q[WIDTH-1]};
        shift_op = 1'b1;
      end
      MODE_SRA: begin
        q_next   = {q[WIDTH-1], q[WIDTH-1:1]};
        shift_op = 1'b1;
      end
      MODE_RSVD: q_next = q;
    endcase
  end

  assign cnt_full = (cnt == CNT_MAX);

  // Clear outranks the enable gate; done only fires on the edge that
  // takes the counter from its last step into saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (!en) begin
      done <= 1'b0;
    end else begin
      q    <= q_next;
      done <= 1'b0;
      if (mode_e'(mode) == MODE_LOAD) begin
        cnt <= '0;
      end else if (shift_op && !cnt_full) begin
        cnt  <= cnt + CW'(1);
        done <= (cnt == CNT_LAST);
      end
    end
  end

  assign so_msb = q[WIDTH-1];
  assign so_lsb = q[0];

endmodule

// File: tb/tb_gated_shift_register.sv
// Directed bench for gated_shift_register (WIDTH=8): an integer-arithmetic
// reference model checked every cycle, plus hand-computed literal checks.
module tb_gated_shift_register;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic [W-1:0] d = '0;
  logic         si_msb = 1'b0;
  logic         si_lsb = 1'b0;
  logic [W-1:0] q;
  logic         so_msb;
  logic         so_lsb;
  logic [CW-1:0] cnt;
  logic         done;

  int tests = 0;
  int fails = 0;
  bit model_on = 1'b0;

  gated_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode), .d(d),
    .si_msb(si_msb), .si_lsb(si_lsb), .q(q), .so_msb(so_msb),
    .so_lsb(so_lsb), .cnt(cnt), .done(done)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: register value as an integer, count as shifts seen
  int m_q = 0;
  int m_cnt = 0;
  int m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      m_q = 0; m_cnt = 0; m_done = 0;
    end else if (!en) begin
      m_done = 0;
    end else begin
      m_done = 0;
      case (int'(mode))
        1: begin m_q = int'(d); m_cnt = 0; end
        2: m_q = (m_q / 2) + (si_msb ? 128 : 0);
        3: m_q = ((m_q * 2) % 256) + (si_lsb ? 1 : 0);
        4: m_q = (m_q / 2) + ((m_q % 2) * 128);
        5: m_q = ((m_q * 2) % 256) + (m_q / 128);
        6: m_q = (m_q / 2) + (m_q >= 128 ? 128 : 0);
        default: ;
      endcase
      if (mode >= 3'd2 && mode <= 3'd6 && m_cnt < W) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == W) m_done = 1;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (model_on) begin
      check("q", int'(q), m_q);
      check("cnt", int'(cnt), m_cnt);
      check("done", int'(done), m_done);
      check("so_msb", int'(so_msb), m_q / 128);
      check("so_lsb", int'(so_lsb), m_q % 2);
    end
  end

  // driver: apply inputs, let one active edge pass, settle 1 time unit
  task automatic cyc(input logic e, input logic c, input logic [2:0] m,
                     input logic [W-1:0] dv, input logic sm, input logic sl);
    en = e; clr = c; mode = m; d = dv; si_msb = sm; si_lsb = sl;
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic en; logic clr; logic [2:0] mode; logic [7:0] d; logic sm; logic sl;
  } vec_t;

  vec_t vecs [16];
  logic [7:0] so_exp;

  initial begin
    vecs[0]  = '{1, 0, 3'b001, 8'h5A, 0, 0};
    vecs[1]  = '{1, 0, 3'b011, 8'h00, 0, 1};
    vecs[2]  = '{1, 0, 3'b010, 8'h00, 1, 0};
    vecs[3]  = '{1, 0, 3'b100, 8'h00, 0, 0};
    vecs[4]  = '{0, 0, 3'b101, 8'h00, 0, 0};
    vecs[5]  = '{1, 0, 3'b101, 8'h00, 0, 0};
    vecs[6]  = '{1, 0, 3'b111, 8'hFF, 1, 1};
    vecs[7]  = '{1, 0, 3'b110, 8'h00, 0, 0};
    vecs[8]  = '{1, 0, 3'b001, 8'hC3, 0, 0};
    vecs[9]  = '{1, 0, 3'b110, 8'h00, 0, 1};
    vecs[10] = '{1, 0, 3'b011, 8'h00, 1, 0};
    vecs[11] = '{0, 0, 3'b001, 8'h11, 0, 0};
    vecs[12] = '{1, 0, 3'b000, 8'h22, 1, 1};
    vecs[13] = '{1, 1, 3'b010, 8'h00, 1, 1};
    vecs[14] = '{1, 0, 3'b010, 8'h00, 1, 0};
    vecs[15] = '{1, 0, 3'b100, 8'h00, 0, 0};

    // reset state, asserted with no clock edge needed
    #2;
    check("reset_q", int'(q), 0);
    check("reset_cnt", int'(cnt), 0);
    check("reset_done", int'(done), 0);
    check("reset_so", int'({so_msb, so_lsb}), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    model_on = 1'b1;

    // load then hold
    cyc(1, 0, 3'b001, 8'hA5, 0, 0);
    check("load_q", int'(q), 8'hA5);
    check("load_cnt", int'(cnt), 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 3'b000, 8'h00, 1, 1);
    check("hold_q", int'(q), 8'hA5);

    // 0x81 shifted right 8 times, bits leaving on so_lsb
    cyc(1, 0, 3'b001, 8'h81, 0, 0);
    so_exp = 8'b1000_0001;
    for (int i = 0; i < 8; i++) begin
      check("srl_so_lsb", int'(so_lsb), int'(so_exp[7-i]));
      cyc(1, 0, 3'b010, 8'h00, 0, 0);
      check("srl_done", int'(done), (i == 7) ? 1 : 0);
    end
    check("srl_q", int'(q), 0);
    check("srl_cnt", int'(cnt), 8);

    // saturation: no further count or done; load restarts
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 3'b011, 8'h00, 0, 1);
      check("sat_cnt", int'(cnt), 8);
      check("sat_done", int'(done), 0);
    end
    cyc(1, 0, 3'b001, 8'h3C, 0, 0);
    check("reload_cnt", int'(cnt), 0);

    // rotate left 8 times returns the original value
    for (int i = 0; i < 8; i++) cyc(1, 0, 3'b101, 8'h00, 0, 0);
    check("rol8_q", int'(q), 8'h3C);
    cyc(1, 0, 3'b001, 8'h80, 0, 0);
    cyc(1, 0, 3'b110, 8'h00, 0, 0);
    check("sra_q", int'(q), 8'hC0);

    // clear beats the enable gate
    cyc(1, 0, 3'b001, 8'hFF, 0, 0);
    cyc(1, 0, 3'b011, 8'h00, 0, 1);
    cyc(0, 1, 3'b011, 8'h00, 0, 1);
    check("clr_q", int'(q), 0);
    check("clr_cnt", int'(cnt), 0);

    // async reset in the middle of a shift sequence
    cyc(1, 0, 3'b001, 8'hF0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 3'b010, 8'h00, 1, 0);
    check("pre_rst_cnt", int'(cnt), 4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_q", int'(q), 0);
    check("mid_rst_cnt", int'(cnt), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 3'b010, 8'h00, 1, 0);
      check("post_rst_done", int'(done), (i == 7) ? 1 : 0);
    end
    check("post_rst_q", int'(q), 8'hFF);
    cyc(0, 0, 3'b010, 8'h00, 1, 0);
    check("en_off_done", int'(done), 0);

    // mixed directed vectors, checked by the model only
    for (int i = 0; i < 16; i++)
      cyc(vecs[i].en, vecs[i].clr, vecs[i].mode, vecs[i].d, vecs[i].sm, vecs[i].sl);

    @(negedge clk);
    model_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
